payload_char_feeder: RTL

//  Front end of the payload engines. Takes packet payload as a 64-bit AXI-Stream and serialises it to one byte per cycle.

---
 rtl/payload_char_feeder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/payload_char_feeder.sv
// Serialises a 64-bit AXI-Stream payload to one byte per cycle and maps each byte to char-class lines.
// Optional macro FEEDER_DEPTH_LIMIT_EN caps the number of bytes fed to the engines per packet.
module payload_char_feeder #(
  parameter int DATA_WIDTH  = 64,
  parameter int NUM_CLASSES = 128,
  parameter int DEPTH_LIMIT = 1460
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic                      cls_we,
  input  logic [7:0]                cls_addr,
  input  logic [NUM_CLASSES-1:0]    cls_wdata,
  output logic [NUM_CLASSES-1:0]    char_cls,
  output logic                      eng_en,
  output logic                      eng_sod,
  output logic                      eng_done
);
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {S_IDLE, S_SOD, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t                 r_state, w_next;
  logic [DATA_WIDTH-1:0]  r_hold_data;
  logic [LANES-1:0]       r_hold_keep;
  logic                   r_hold_last, r_hold_vld, r_run;
  logic [LANES-1:0]       w_lane_oh, w_keep_rem;
  logic [7:0]             w_byte;
  logic                   w_beat_end, w_tready, w_accept, w_emit, w_feed;
  logic                   w_flush, w_sod, w_done;
  logic [7:0]             r_byte;
  logic                   r_en_d1, r_flush_d1, r_sod_d1, r_done_d1;
  logic [NUM_CLASSES-1:0] r_tbl [256];

  // Lowest remaining kept lane is the next byte; skipped lanes cost nothing.
  always_comb begin
    w_lane_oh  = r_hold_keep & (~r_hold_keep + LANES'(1));
    w_keep_rem = r_hold_keep & ~w_lane_oh;
    w_byte     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_lane_oh[i]) w_byte = w_byte | r_hold_data[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_tready   = 1'b0;
    w_emit     = 1'b0;
    w_flush    = 1'b0;
    w_sod      = 1'b0;
    w_done     = 1'b0;
    w_beat_end = r_hold_vld && (w_keep_rem == '0);
    case (r_state)
      S_IDLE: begin
        w_tready = r_run;
        if (s_axis_tvalid && r_run) w_next = S_SOD;
      end
      S_SOD: begin
        w_sod  = 1'b1;
        w_next = S_STREAM;
      end
      S_STREAM: begin
        w_emit   = r_hold_vld && (r_hold_keep != '0);
        w_tready = (!r_hold_vld || w_beat_end) && !(r_hold_vld && r_hold_last);
        if (w_beat_end && r_hold_last) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        w_flush = 1'b1;
        w_next  = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept      = w_tready && s_axis_tvalid;
  assign s_axis_tready = w_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run       <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_hold_keep <= '0;
      r_hold_data <= '0;
      r_hold_last <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_accept) begin
        r_hold_vld  <= 1'b1;
        r_hold_keep <= s_axis_tkeep;
        r_hold_data <= s_axis_tdata;
        r_hold_last <= s_axis_tlast;
      end else if (r_state == S_STREAM && r_hold_vld) begin
        r_hold_vld  <= !w_beat_end;
        r_hold_keep <= w_keep_rem;
      end
    end
  end

`ifdef FEEDER_DEPTH_LIMIT_EN
  logic [15:0] r_fed_cnt;

  // Bytes past the limit still drain one per cycle but are not fed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_fed_cnt <= '0;
    else if (w_sod)  r_fed_cnt <= '0;
    else if (w_feed) r_fed_cnt <= r_fed_cnt + 16'd1;
  end

  assign w_feed = w_emit && (r_fed_cnt < 16'(DEPTH_LIMIT));
`else
  assign w_feed = w_emit;
`endif

  // Read-first: a same-cycle write to the addressed entry is not visible yet.
  always_ff @(posedge clk) begin
    if (cls_we) r_tbl[cls_addr] <= cls_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte     <= '0;
      r_en_d1    <= 1'b0;
      r_flush_d1 <= 1'b0;
      r_sod_d1   <= 1'b0;
      r_done_d1  <= 1'b0;
      eng_en     <= 1'b0;
      eng_sod    <= 1'b0;
      eng_done   <= 1'b0;
      char_cls   <= '0;
    end else begin
      r_byte     <= w_byte;
      r_en_d1    <= w_feed || w_flush;
      r_flush_d1 <= w_flush;
      r_sod_d1   <= w_sod;
      r_done_d1  <= w_done;
      eng_en     <= r_en_d1;
      eng_sod    <= r_sod_d1;
      eng_done   <= r_done_d1;
      char_cls   <= (r_en_d1 && !r_flush_d1) ? r_tbl[r_byte] : '0;
    end
  end

endmodule
